ysyx_041514_if_queue: RTL and testbench

Fetch-stage instruction queue directly downstream of the PC register. It records the PC of every icache fetch the PC register issues and pairs each in-order icache response with its PC. It buffers the resulting {pc, inst} pairs and presents them to decode with a valid/ready handshake. It also throws away responses to fetches that were still in flight when a flush/redirect occurred, and generates the back-pressure that stalls the PC register.

---
 rtl/ysyx_041514_if_queue_pkg.sv | 21 ++
 rtl/ysyx_041514_sync_fifo.sv | 56 +++++
 rtl/ysyx_041514_if_queue.sv | 98 +++++++++
 tb/tb_ysyx_041514_if_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041514_if_queue_pkg.sv
// Shared types and widths for the fetch-stage instruction queue.
// XLEN normally comes from sysconfig.v; the guarded defaults let this slice build standalone.
`ifndef ysyx_041514_XLEN
`define ysyx_041514_XLEN 64
`endif
`ifndef ysyx_041514_XLEN_BUS
`define ysyx_041514_XLEN_BUS 63:0
`endif

package ysyx_041514_if_queue_pkg;
  localparam int XLEN = `ysyx_041514_XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } iq_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ysyx_041514_sync_fifo.sv
// Small synchronous FIFO with registered storage; head reads straight from the entry array.
// Clear has priority over push/pop; push into a full FIFO is allowed only alongside a pop.
module ysyx_041514_sync_fifo
  import ysyx_041514_if_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  input  logic                      clear,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]          head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ptr_inc(wptr);
      end
      if (do_pop) rptr <= ptr_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ysyx_041514_if_queue.sv
// Fetch-stage instruction queue: pairs in-order icache responses with issued PCs,
// buffers {pc, inst} for decode, and discards responses to fetches killed by a flush.
module ysyx_041514_if_queue
  import ysyx_041514_if_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  input  logic [XLEN-1:0] req_pc_i,
  output logic            req_ready_o,
  input  logic            resp_valid_i,
  input  logic [31:0]     resp_inst_i,
  input  logic            flush_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_inst_o,
  input  logic            id_ready_i,
  output logic            err_o
);
  localparam int PW = cnt_w(MAX_OUT);
  localparam int QW = cnt_w(DEPTH);

  logic [PW-1:0]   pend_cnt, drop_cnt, drop_nxt;
  logic [QW-1:0]   q_cnt;
  logic [XLEN-1:0] pend_head;
  logic            pend_full, pend_empty, q_full, q_empty;
  iq_entry_t       q_head, q_in;
  logic [31:0]     out_sum, fill_sum;
  logic            accept, resp_drop, resp_live, resp_spur;

  // Counting killed fetches against MAX_OUT keeps the icache from being overrun,
  // and reserving a queue slot per live fetch means a response never stalls.
  assign out_sum     = 32'(pend_cnt) + 32'(drop_cnt);
  assign fill_sum    = 32'(pend_cnt) + 32'(q_cnt);
  assign req_ready_o = (out_sum < 32'(MAX_OUT)) & (fill_sum < 32'(DEPTH)) & ~pend_full & ~q_full;
  assign accept      = req_valid_i & req_ready_o & ~flush_i;

  assign resp_drop = resp_valid_i & (drop_cnt != '0);
  assign resp_live = resp_valid_i & (drop_cnt == '0) & ~pend_empty;
  assign resp_spur = resp_valid_i & (drop_cnt == '0) & pend_empty;

  assign q_in.pc   = pend_head;
  assign q_in.inst = resp_inst_i;

  ysyx_041514_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (req_pc_i),
    .pop   (resp_live & ~flush_i),
    .clear (flush_i),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_cnt),
    .head  (pend_head)
  );

  ysyx_041514_sync_fifo #(.WIDTH($bits(iq_entry_t)), .DEPTH(DEPTH)) u_iq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp_live & ~flush_i),
    .wdata (q_in),
    .pop   (id_valid_o & id_ready_i & ~flush_i),
    .clear (flush_i),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt),
    .head  (q_head)
  );

  assign id_valid_o = ~q_empty;
  assign id_pc_o    = q_head.pc;
  assign id_inst_o  = q_head.inst;

  // On flush every live fetch becomes a drop, less one if its response lands now.
  always_comb begin
    drop_nxt = drop_cnt;
    if (flush_i) begin
      if (out_sum == 32'd0) drop_nxt = '0;
      else                  drop_nxt = PW'(out_sum - 32'(resp_valid_i));
    end else if (resp_drop) begin
      drop_nxt = drop_cnt - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      drop_cnt <= drop_nxt;
      if (resp_spur) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_041514_if_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_ysyx_041514_if_queue;
  import ysyx_041514_if_queue_pkg::*;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst_n, req_valid_i, resp_valid_i, flush_i, id_ready_i;
  logic [XLEN-1:0] req_pc_i;
  logic [31:0]     resp_inst_i;
  logic            req_ready_o, id_valid_o, err_o;
  logic [XLEN-1:0] id_pc_o;
  logic [31:0]     id_inst_o;

  always #5 clk = ~clk;

  ysyx_041514_if_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_pc_i     (req_pc_i),
    .req_ready_o  (req_ready_o),
    .resp_valid_i (resp_valid_i),
    .resp_inst_i  (resp_inst_i),
    .flush_i      (flush_i),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_ready_i   (id_ready_i),
    .err_o        (err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: outstanding live PCs, queued pairs, count of fetches to discard
  logic [XLEN-1:0] m_pend[$];
  logic [XLEN-1:0] m_qpc[$];
  logic [31:0]     m_qinst[$];
  int              m_drop;
  logic            m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready();
    return (m_pend.size() + m_drop < MAX_OUT) && (m_pend.size() + m_qpc.size() < DEPTH);
  endfunction

  function automatic int m_out();
    return m_pend.size() + m_drop;
  endfunction

  // called at a negedge: check outputs, drive one cycle, advance model
  task automatic step(input logic rv, input logic [XLEN-1:0] pc, input logic sv,
                      input logic [31:0] inst, input logic fl, input logic idr);
    logic rdy;
    chk("id_valid", id_valid_o, m_qpc.size() != 0);
    if (m_qpc.size() != 0) begin
      chk("id_pc", id_pc_o, m_qpc[0]);
      chk("id_inst", id_inst_o, m_qinst[0]);
    end
    chk("req_ready", req_ready_o, m_ready());
    chk("err", err_o, m_err);
    req_valid_i = rv; req_pc_i = pc; resp_valid_i = sv; resp_inst_i = inst;
    flush_i = fl; id_ready_i = idr;
    rdy = m_ready();
    @(posedge clk);
    if (sv && m_drop == 0 && m_pend.size() == 0) m_err = 1'b1;
    if (fl) begin
      m_drop = m_drop + m_pend.size() - ((sv && (m_drop + m_pend.size()) > 0) ? 1 : 0);
      m_pend.delete(); m_qpc.delete(); m_qinst.delete();
    end else begin
      if (m_qpc.size() != 0 && idr) begin
        void'(m_qpc.pop_front()); void'(m_qinst.pop_front());
      end
      if (sv) begin
        if (m_drop > 0) m_drop--;
        else if (m_pend.size() != 0) begin
          m_qpc.push_back(m_pend.pop_front());
          m_qinst.push_back(inst);
        end
      end
      if (rv && rdy) m_pend.push_back(pc);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_pc_i = '0; resp_valid_i = 1'b0;
    resp_inst_i = '0; flush_i = 1'b0; id_ready_i = 1'b0;
    @(posedge clk);
    m_pend.delete(); m_qpc.delete(); m_qinst.delete(); m_drop = 0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_id_valid", id_valid_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_err", err_o, 1'b0);
    chk("rst_id_pc", id_pc_o, '0);
    chk("rst_id_inst", id_inst_o, '0);
  endtask

  initial begin
    do_reset();

    // basic flow
    step(1'b1, 64'h8000_0000, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h8000_0004, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    chk("basic_pc0", id_pc_o, 64'h8000_0000);
    chk("basic_inst0", id_inst_o, 32'h0000_0013);
    step(1'b0, '0, 1'b1, 32'h0010_0093, 1'b0, 1'b1);
    chk("basic_pc1", id_pc_o, 64'h8000_0004);
    chk("basic_inst1", id_inst_o, 32'h0010_0093);
    idle(2);

    // back-pressure
    step(1'b1, 64'h100, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 64'h104, 1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 64'h108, 1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 64'h10c, 1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h44, 1'b0, 1'b0);
    chk("bp_stall", req_ready_o, 1'b0);
    idle(4);
    chk("bp_release", req_ready_o, 1'b1);

    // flush with two in flight
    step(1'b1, 64'h200, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h204, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    chk("fl_drop2", 64'(u_dut.drop_cnt), 64'd2);
    chk("fl_empty", id_valid_o, 1'b0);
    step(1'b0, '0, 1'b1, 32'hbad0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'hbad1, 1'b0, 1'b1);
    step(1'b1, 64'h8000_0100, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'hdead_beef, 1'b0, 1'b1);
    chk("fl_new_pc", id_pc_o, 64'h8000_0100);
    chk("fl_new_inst", id_inst_o, 32'hdead_beef);
    idle(1);

    // flush together with a response
    step(1'b1, 64'h300, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h304, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'hbad2, 1'b1, 1'b1);
    chk("flr_drop1", 64'(u_dut.drop_cnt), 64'd1);
    step(1'b0, '0, 1'b1, 32'hbad3, 1'b0, 1'b1);
    chk("flr_discard", id_valid_o, 1'b0);
    step(1'b1, 64'h400, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h5555, 1'b0, 1'b1);
    chk("flr_pc", id_pc_o, 64'h400);
    idle(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic rv, sv, fl, idr;
      logic [XLEN-1:0] pc;
      rv  = ($urandom % 3) != 0;
      sv  = (m_out() > 0) && ($urandom % 2 == 1);
      fl  = ($urandom % 12) == 0;
      idr = ($urandom % 4) != 0;
      pc  = XLEN'({$urandom, $urandom}) & ~XLEN'(3);
      step(rv, pc, sv, $urandom, fl, idr);
    end

    // drain, then a spurious response
    for (int i = 0; i < 20 && m_out() > 0; i++) step(1'b0, '0, 1'b1, $urandom, 1'b0, 1'b1);
    idle(DEPTH + 1);
    step(1'b0, '0, 1'b1, 32'h7777, 1'b0, 1'b1);
    chk("spur_valid", id_valid_o, 1'b0);
    chk("spur_err", err_o, 1'b1);
    idle(2);
    chk("spur_sticky", err_o, 1'b1);

    // reset in the middle of a drop sequence
    step(1'b1, 64'h500, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h504, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    chk("rd_drop2", 64'(u_dut.drop_cnt), 64'd2);
    do_reset();
    step(1'b0, '0, 1'b1, 32'h9999, 1'b0, 1'b1);
    chk("rd_err", err_o, 1'b1);
    chk("rd_valid", id_valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
